// File: rtl/rsa_pkg.sv
// Shared types and sizing for the RSA exponentiation datapath.
package rsa_pkg;

    localparam int unsigned DefaultLen = 256;
    localparam int unsigned IdxWidth   = $clog2(DefaultLen);

    typedef enum logic [2:0] {
        StIdle,
        StConvIn,
        StSqr,
        StMul,
        StConvOut,
        StDone
    } state_e;

endpackage

// File: rtl/mont_redc.sv
// Combinational Montgomery reduction: res_o = t_i * R^-1 mod n_i, fully reduced, for t_i < n_i * R.
module mont_redc #(
    parameter int unsigned LEN = 256
) (
    input  logic [2*LEN-1:0] t_i,
    input  logic [LEN-1:0]   n_i,
    input  logic [LEN-1:0]   n_prime_i,
    output logic [LEN-1:0]   res_o
);

    localparam int unsigned SW = 2 * LEN + 1;

    logic [LEN-1:0] m;
    logic [SW-1:0]  sum;
    logic [LEN:0]   u;

    always_comb begin
        m   = t_i[LEN-1:0] * n_prime_i;
        // t + m*n < 2*n*R, so one extra bit holds the sum without overflow.
        sum = SW'(t_i) + SW'(m) * SW'(n_i);
        u   = (LEN + 1)'(sum >> LEN);
        if (u >= {1'b0, n_i}) begin
            res_o = LEN'(u - {1'b0, n_i});
        end else begin
            res_o = u[LEN-1:0];
        end
    end

endmodule

// File: rtl/mont_modexp_seq.sv
// Left-to-right square-and-multiply modular exponentiation in the Montgomery domain,
// time-sharing one mont_redc and one LEN x LEN multiplier (2 cycles per modular multiply).
module mont_modexp_seq
    import rsa_pkg::*;
#(
    parameter int unsigned LEN = DefaultLen
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [LEN-1:0] base,
    input  logic [LEN-1:0] exp,
    input  logic [LEN-1:0] n,
    input  logic [LEN-1:0] n_prime,
    input  logic [LEN-1:0] r2,
    input  logic [LEN-1:0] r1,
    output logic           ready,
    output logic           done,
    output logic [LEN-1:0] res
);

    localparam int unsigned IdxW = $clog2(LEN);
    localparam int unsigned PW   = 2 * LEN;

    state_e            state_q, state_d;
    logic              phase_q, phase_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [LEN-1:0]    base_q, base_d;
    logic [LEN-1:0]    exp_q, exp_d;
    logic [LEN-1:0]    n_q, n_d;
    logic [LEN-1:0]    np_q, np_d;
    logic [LEN-1:0]    r2_q, r2_d;
    logic [LEN-1:0]    acc_q, acc_d;
    logic [LEN-1:0]    bm_q, bm_d;
    logic [LEN-1:0]    res_q, res_d;
    logic [PW-1:0]     prod_q, prod_d;

    logic [LEN-1:0]    op_a, op_b;
    logic [LEN-1:0]    redc_out;

    mont_redc #(
        .LEN(LEN)
    ) u_mont_redc (
        .t_i      (prod_q),
        .n_i      (n_q),
        .n_prime_i(np_q),
        .res_o    (redc_out)
    );

    always_comb begin
        op_a = '0;
        op_b = '0;
        unique case (state_q)
            StConvIn:  begin op_a = base_q; op_b = r2_q;        end
            StSqr:     begin op_a = acc_q;  op_b = acc_q;       end
            StMul:     begin op_a = acc_q;  op_b = bm_q;        end
            StConvOut: begin op_a = acc_q;  op_b = LEN'(1);     end
            default:   begin op_a = '0;     op_b = '0;          end
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        base_d  = base_q;
        exp_d   = exp_q;
        n_d     = n_q;
        np_d    = np_q;
        r2_d    = r2_q;
        acc_d   = acc_q;
        bm_d    = bm_q;
        res_d   = res_q;
        prod_d  = prod_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exp;
                    n_d     = n;
                    np_d    = n_prime;
                    r2_d    = r2;
                    acc_d   = r1;
                    idx_d   = IdxW'(LEN - 1);
                    phase_d = 1'b0;
                    state_d = StConvIn;
                end
            end
            StConvIn, StSqr, StMul, StConvOut: begin
                if (!phase_q) begin
                    prod_d  = PW'(op_a) * PW'(op_b);
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    unique case (state_q)
                        StConvIn: begin
                            bm_d    = redc_out;
                            state_d = StSqr;
                        end
                        StSqr: begin
                            acc_d = redc_out;
                            if (exp_q[idx_q]) begin
                                state_d = StMul;
                            end else if (idx_q == '0) begin
                                state_d = StConvOut;
                            end else begin
                                idx_d   = idx_q - 1'b1;
                                state_d = StSqr;
                            end
                        end
                        StMul: begin
                            acc_d = redc_out;
                            if (idx_q == '0) begin
                                state_d = StConvOut;
                            end else begin
                                idx_d   = idx_q - 1'b1;
                                state_d = StSqr;
                            end
                        end
                        default: begin
                            res_d   = redc_out;
                            state_d = StDone;
                        end
                    endcase
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= 1'b0;
            idx_q   <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            n_q     <= '0;
            np_q    <= '0;
            r2_q    <= '0;
            acc_q   <= '0;
            bm_q    <= '0;
            res_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            n_q     <= n_d;
            np_q    <= np_d;
            r2_q    <= r2_d;
            acc_q   <= acc_d;
            bm_q    <= bm_d;
            res_q   <= res_d;
            prod_q  <= prod_d;
        end
    end

    assign ready = (state_q == StIdle);
    assign done  = (state_q == StDone);
    assign res   = res_q;

endmodule

// File: tb/tb_mont_modexp_seq.sv
// Self-checking bench for mont_modexp_seq over the secp256k1 field prime.
module tb_mont_modexp_seq;

    localparam int unsigned L = 256;
    localparam logic [L-1:0] NMOD =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [L-1:0] NPRM =
        256'hc9bd1905155383999c46c2c295f2b761bcb223fedc24a059d838091dd2253531;
    localparam logic [L-1:0] R1C = 256'h1000003D1;
    localparam logic [L-1:0] R2C = 256'h1000007A2000E90A1;

    typedef struct {
        logic [L-1:0] base;
        logic [L-1:0] expo;
        logic [L-1:0] res;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [L-1:0] base = '0, exp_v = '0, n = '0, n_prime = '0, r2 = '0, r1 = '0;
    logic         ready, done;
    logic [L-1:0] res;

    int           checks = 0;
    int           failures = 0;
    int           done_cnt = 0;
    logic [L-1:0] sb_q[$];
    vec_t         vecs[8];

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    mont_modexp_seq #(
        .LEN(L)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .base   (base),
        .exp    (exp_v),
        .n      (n),
        .n_prime(n_prime),
        .r2     (r2),
        .r1     (r1),
        .ready  (ready),
        .done   (done),
        .res    (res)
    );

    task automatic chk(input string name, input logic [L-1:0] act, input logic [L-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic run(input vec_t v, input int pulse_at, input bit pulse_done,
                       input int reset_at, input bit scramble);
        int           lat;
        int           d0;
        int           busy_ready;
        bit           was_reset;
        logic [L-1:0] want;
        lat = 0;
        busy_ready = 0;
        was_reset = 1'b0;
        @(negedge clk);
        base = v.base; exp_v = v.expo; n = NMOD; n_prime = NPRM; r2 = R2C; r1 = R1C;
        start = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        sb_q.push_back(v.res);
        while (!done && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
            if (ready) busy_ready++;
            start = (lat == pulse_at);
            if (lat == pulse_at) base = 256'd3;
            if (scramble && lat == 1) begin
                base    = {8{$urandom}};
                exp_v   = {8{$urandom}};
                n       = {8{$urandom}};
                n_prime = {8{$urandom}};
                r2      = {8{$urandom}};
                r1      = {8{$urandom}};
            end
            if (lat == reset_at) begin
                rst_n = 1'b0;
                #1;
                chk("reset_ready", ready, 1);
                chk("reset_res", res, 0);
                chk("reset_done", done, 0);
                was_reset = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (was_reset) begin
            void'(sb_q.pop_front());
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (1100) @(posedge clk);
            #1;
            chk("reset_no_done", done_cnt - d0, 0);
            chk("reset_idle_ready", ready, 1);
            return;
        end
        chk("done_seen", done, 1);
        chk("latency", lat, v.lat);
        chk("ready_low_busy", busy_ready, 0);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            want = sb_q.pop_front();
            chk("res", res, want);
        end
        if (pulse_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("ready_after", ready, 1);
        if (pulse_at >= 0 || pulse_done) begin
            repeat (1100) @(posedge clk);
            #1;
            chk("res_held", res, v.res);
            chk("ready_idle", ready, 1);
        end
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        vecs[0] = '{base: 256'd2,      expo: 256'd10,     res: 256'h400,       lat: 520};
        vecs[1] = '{base: 256'd3,      expo: 256'd0,      res: 256'd1,         lat: 516};
        vecs[2] = '{base: 256'd0,      expo: 256'd5,      res: 256'd0,         lat: 520};
        vecs[3] = '{base: 256'd5,      expo: NMOD - 1,    res: 256'd1,         lat: 1014};
        vecs[4] = '{base: 256'd7,      expo: 256'd3,      res: 256'h157,       lat: 520};
        vecs[5] = '{base: NMOD - 1,    expo: 256'd2,      res: 256'd1,         lat: 518};
        vecs[6] = '{base: NMOD + 3,    expo: 256'd1,      res: 256'd3,         lat: 518};
        vecs[7] = '{base: {L{1'b1}},   expo: 256'd1,      res: 256'h1000003D0, lat: 518};

        #1;
        chk("por_ready", ready, 1);
        chk("por_done", done, 0);
        chk("por_res", res, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run(vecs[i], -1, 1'b0, -1, 1'b0);
        end

        // start during busy and during DONE must both be ignored
        run(vecs[0], 100, 1'b1, -1, 1'b0);
        // abort by reset mid-run, then a clean rerun
        run(vecs[3], -1, 1'b0, 300, 1'b0);
        run(vecs[0], -1, 1'b0, -1, 1'b0);
        // inputs changed after start must not affect the result
        run(vecs[4], -1, 1'b0, -1, 1'b1);
        run(vecs[3], -1, 1'b0, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mont_modexp_seq.md
Name: mont_modexp_seq

Overview:
Sequencer that computes res = base^exp mod n by time-sharing one existing mont_redc instance and one LEN×LEN multiplier. It uses left-to-right square-and-multiply in the Montgomery domain, including the conversions into and out of that domain. It is the RSA core's exponentiation engine and sits between the key/message registers and the output buffer. mont_redc is combinational and returns x·R⁻¹ mod n, fully reduced to [0,n), for any x < n·R, where R = 2^LEN.

Parameters:
LEN, 256, operand width in bits; R = 2^LEN.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; accepted only when ready=1
base  input  LEN  plain-domain base; any value < R
exp  input  LEN  exponent; all LEN bits are scanned
n  input  LEN  odd modulus
n_prime  input  LEN  constant required by mont_redc for n
r2  input  LEN  R² mod n
r1  input  LEN  R mod n, i.e. Montgomery one
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse when res becomes valid
res  output  LEN  result; held until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ready=1; done=0; res=0. All internal registers cleared. Reset mid-operation aborts with no done pulse.
- start sampled with ready=1: latch base, exp, n, n_prime, r2. Set acc=r1 and bit index i=LEN-1. Go to CONV_IN. start while ready=0 is ignored, including in DONE.
- Each modular multiply takes 2 cycles, selected by a phase bit:
  - phase 0 (MULT): prod <= a*b, a 2·LEN-bit register.
  - phase 1 (REDC): dest <= mont_redc(prod).
- Operand selection per state:
  - CONV_IN: a=base, b=r2. dest=bm (Montgomery base). Next state SQR.
  - SQR: a=acc, b=acc. dest=acc. If exp[i]=1, next state MUL. Otherwise, if i==0, next state CONV_OUT; else i--, next state SQR.
  - MUL: a=acc, b=bm. dest=acc. If i==0, next state CONV_OUT; else i--, next state SQR.
  - CONV_OUT: a=acc, b=1. dest=res. Next state DONE.
  - DONE: done=1 for this single cycle; next state IDLE (ready=1).
- Latency: P = 2·(LEN + popcount(exp) + 2) cycles from the start-sampling edge to the edge that sets res and done. Timing is fixed by exp and independent of base.
- res is updated only at the CONV_OUT REDC edge; it is stable at all other times, including while busy.
- exp=0 gives res = 1 mod n. base=0 gives res=0 for exp≠0.
- Decrement of i never wraps: i==0 always exits to CONV_OUT.
- Combinational inputs n and n_prime into mont_redc come from the latched copies, so input changes while busy have no effect.

Decomposition:
- rsa_pkg holds:
  - state enum: IDLE, CONV_IN, SQR, MUL, CONV_OUT, DONE;
  - default LEN;
  - localparam of the index width, $clog2(LEN).
- One sub-module: the existing mont_redc, instantiated once with .LEN(LEN). The multiplier is inline.
- No other sub-module.

Test Plan:
Common setup for all scenarios, LEN=256:
- n = FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
- n_prime = c9bd1905155383999c46c2c295f2b761bcb223fedc24a059d838091dd2253531
- r1 = 1000003D1
- r2 = 1000007A2000E90A1

Scenarios:
1. base=2, exp=10 -> res=0x400; done exactly 2·(256+2+2)=520 cycles after the start edge; ready low throughout.
2. base=3, exp=0 -> res=1 after 516 cycles. base=0, exp=5 -> res=0 after 520 cycles.
3. base=5, exp=n-1 (popcount 249) -> res=1 (Fermat) after 2·(256+249+2)=1014 cycles.
4. start pulsed again at cycle 100 and in the DONE cycle of scenario 1 -> both ignored; res stays 0x400; only one done pulse.
5. rst_n driven low at cycle 300 of scenario 3 -> asynchronously: ready=1, res=0, no done pulse. Rerun scenario 1 afterwards -> 0x400.
6. Inputs base/exp/n changed to random values one cycle after start -> result still that of the latched values.
